// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with saturating direction counters
//
// Ports:
//   clk, rst_n            single rising-edge clock, synchronous active-low reset
//   fetch_pc              PC being fetched; combinational lookup
//   fetch_hit/taken       lookup hit and predicted direction
//   fetch_target          stored target of the indexed entry (driven even on miss)
//   resolve_*             branch resolved in the ALU stage plus its carried prediction
//   pc_sel                0 PC+4, 1 fetch_target, 2/3 redirect_pc (fall-through/taken recovery)
//   redirect_pc, flush    recovery address and IF/ID squash
//   stat_branches         saturating count of resolved branches
//   stat_mispredicts      saturating count of mispredicted branches
module branch_predictor_btb #(
  parameter int ADDR_W   = 32,
  parameter int IDX_BITS = 4,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_hit,
  output logic              fetch_taken,
  output logic [ADDR_W-1:0] fetch_target,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic [ADDR_W-1:0] resolve_target,
  input  logic              resolve_taken,
  input  logic              resolve_pred_hit,
  input  logic              resolve_pred_taken,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = ADDR_W - IDX_BITS - 2;

  // Weakly taken is MSB set with the rest clear; weakly not-taken is one below it.
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [STAT_W-1:0]   STAT_MAX = '1;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, r_idx;
  logic [TAG_W-1:0]    f_tag, r_tag;
  logic                r_hit;
  logic                pred_dir;
  logic                mispredict;
  logic [ADDR_W-1:0]   pc_plus4;
  logic                unused_pc_lsbs;

  assign f_idx = fetch_pc[IDX_BITS+1:2];
  assign f_tag = fetch_pc[ADDR_W-1:IDX_BITS+2];
  assign r_idx = resolve_pc[IDX_BITS+1:2];
  assign r_tag = resolve_pc[ADDR_W-1:IDX_BITS+2];
  assign unused_pc_lsbs = ^fetch_pc[1:0];

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign fetch_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign fetch_taken  = fetch_hit && ctr_q[f_idx][CTR_BITS-1];
  assign fetch_target = target_q[f_idx];

  // The update re-checks the live table rather than trusting resolve_pred_hit,
  // since the entry may have been replaced between fetch and resolve.
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign pred_dir   = resolve_pred_hit & resolve_pred_taken;
  assign mispredict = rst_n & resolve_valid & (pred_dir != resolve_taken);
  assign pc_plus4   = resolve_pc + ADDR_W'(4);

  assign flush       = mispredict;
  assign redirect_pc = (mispredict && resolve_taken) ? resolve_target : pc_plus4;

  always_comb begin
    pc_sel = 2'd0;
    if (mispredict) begin
      pc_sel = resolve_taken ? 2'd3 : 2'd2;
    end else if (rst_n && fetch_taken) begin
      pc_sel = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (resolve_valid) begin
      if (r_hit) begin
        if (resolve_taken) begin
          if (ctr_q[r_idx] != CTR_MAX) ctr_q[r_idx] <= ctr_q[r_idx] + CTR_BITS'(1);
          target_q[r_idx] <= resolve_target;
        end else if (ctr_q[r_idx] != '0) begin
          ctr_q[r_idx] <= ctr_q[r_idx] - CTR_BITS'(1);
        end
      end else if (resolve_taken) begin
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= resolve_target;
        ctr_q[r_idx]    <= CTR_WT;
      end
      if (stat_branches != STAT_MAX) stat_branches <= stat_branches + STAT_W'(1);
      if (mispredict && (stat_mispredicts != STAT_MAX))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
module tb_branch_predictor_btb;

  localparam int F_HIT = 0, F_TAKEN = 1, F_TARGET = 2, F_PCSEL = 3,
                 F_REDIR = 4, F_FLUSH = 5, F_SB = 6, F_SM = 7;

  typedef struct {
    int          field;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_hit, fetch_taken;
  logic [31:0] fetch_target;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic [31:0] resolve_target = '0;
  logic        resolve_taken = 1'b0;
  logic        resolve_pred_hit = 1'b0;
  logic        resolve_pred_taken = 1'b0;
  logic [1:0]  pc_sel;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] stat_branches, stat_mispredicts;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.ADDR_W(32), .IDX_BITS(4), .CTR_BITS(2), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_pc(fetch_pc), .fetch_hit(fetch_hit), .fetch_taken(fetch_taken),
    .fetch_target(fetch_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_target(resolve_target), .resolve_taken(resolve_taken),
    .resolve_pred_hit(resolve_pred_hit), .resolve_pred_taken(resolve_pred_taken),
    .pc_sel(pc_sel), .redirect_pc(redirect_pc), .flush(flush),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  function automatic logic [31:0] actual(input int f);
    case (f)
      F_HIT:    return {31'd0, fetch_hit};
      F_TAKEN:  return {31'd0, fetch_taken};
      F_TARGET: return fetch_target;
      F_PCSEL:  return {30'd0, pc_sel};
      F_REDIR:  return redirect_pc;
      F_FLUSH:  return {31'd0, flush};
      F_SB:     return {16'd0, stat_branches};
      default:  return {16'd0, stat_mispredicts};
    endcase
  endfunction

  // Monitor: everything pushed during a cycle is compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] a;
        e = sb_q.pop_front();
        a = actual(e.field);
        checks++;
        if (a === e.exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_f(input int f, input logic [31:0] v, input string n);
    sb_q.push_back('{f, v, n});
  endtask

  task automatic step(input logic rst, input logic [31:0] fpc, input logic rv,
                      input logic [31:0] rpc, input logic [31:0] rtgt,
                      input logic rtk, input logic phit, input logic ptk);
    @(posedge clk);
    #1;
    rst_n              = rst;
    fetch_pc           = fpc;
    resolve_valid      = rv;
    resolve_pc         = rpc;
    resolve_target     = rtgt;
    resolve_taken      = rtk;
    resolve_pred_hit   = phit;
    resolve_pred_taken = ptk;
  endtask

  task automatic fetch_only(input logic [31:0] fpc);
    step(1'b1, fpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset: outputs gated while rst_n is low.
    step(1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_f(F_FLUSH, 0, "reset_flush");
    expect_f(F_PCSEL, 0, "reset_pc_sel");
    step(1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Cold miss.
    fetch_only(32'h40);
    expect_f(F_HIT, 0, "cold_hit");
    expect_f(F_PCSEL, 0, "cold_pc_sel");
    expect_f(F_FLUSH, 0, "cold_flush");
    expect_f(F_SB, 0, "cold_stat_br");
    expect_f(F_SM, 0, "cold_stat_mp");

    // Allocate on taken; same-cycle fetch of idx 0 sees the old (empty) entry.
    step(1'b1, 32'h40, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0);
    expect_f(F_FLUSH, 1, "alloc_flush");
    expect_f(F_PCSEL, 3, "alloc_pc_sel");
    expect_f(F_REDIR, 32'h80, "alloc_redirect");
    expect_f(F_HIT, 0, "alloc_collision_hit");

    fetch_only(32'h40);
    expect_f(F_HIT, 1, "alloc_next_hit");
    expect_f(F_TAKEN, 1, "alloc_next_taken");
    expect_f(F_TARGET, 32'h80, "alloc_next_target");
    expect_f(F_PCSEL, 1, "alloc_next_pc_sel");
    expect_f(F_SB, 1, "alloc_stat_br");
    expect_f(F_SM, 1, "alloc_stat_mp");

    // Not-taken recovery: ctr 10 -> 01.
    step(1'b1, 32'h100, 1'b1, 32'h40, 32'h80, 1'b0, 1'b1, 1'b1);
    expect_f(F_PCSEL, 2, "nt_pc_sel");
    expect_f(F_REDIR, 32'h44, "nt_redirect");
    expect_f(F_FLUSH, 1, "nt_flush");
    expect_f(F_HIT, 0, "nt_fetch_alias_miss");

    fetch_only(32'h40);
    expect_f(F_HIT, 1, "nt_next_hit");
    expect_f(F_TAKEN, 0, "nt_next_taken");
    expect_f(F_PCSEL, 0, "nt_next_pc_sel");
    expect_f(F_SM, 2, "nt_stat_mp");

    // Saturation: four correctly predicted taken resolves, ctr 01->10->11->11->11.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h200, 1'b1, 32'h40, 32'h90, 1'b1, 1'b1, 1'b1);
      expect_f(F_FLUSH, 0, $sformatf("sat_flush_%0d", i));
      expect_f(F_PCSEL, 0, $sformatf("sat_pc_sel_%0d", i));
      expect_f(F_REDIR, 32'h44, $sformatf("sat_redirect_%0d", i));
      expect_f(F_SB, 32'(2 + i), $sformatf("sat_stat_br_%0d", i));
      expect_f(F_SM, 2, $sformatf("sat_stat_mp_%0d", i));
    end
    fetch_only(32'h40);
    expect_f(F_TAKEN, 1, "sat_taken");
    expect_f(F_TARGET, 32'h90, "sat_target_rewrite");
    expect_f(F_SB, 6, "sat_stat_br_end");

    // One not-taken resolve, correctly predicted: ctr 11 -> 10.
    step(1'b1, 32'h40, 1'b1, 32'h40, 32'h90, 1'b0, 1'b1, 1'b0);
    expect_f(F_FLUSH, 0, "desat_flush");
    expect_f(F_PCSEL, 1, "desat_pc_sel");
    fetch_only(32'h40);
    expect_f(F_TAKEN, 1, "desat_still_taken");
    expect_f(F_SB, 7, "desat_stat_br");
    expect_f(F_SM, 2, "desat_stat_mp");

    // Aliasing: 0x80 replaces 0x40 at idx 0; same-cycle fetch sees old entry.
    step(1'b1, 32'h40, 1'b1, 32'h80, 32'h100, 1'b1, 1'b0, 1'b0);
    expect_f(F_PCSEL, 3, "alias_pc_sel");
    expect_f(F_REDIR, 32'h100, "alias_redirect");
    expect_f(F_HIT, 1, "collision_old_hit");
    expect_f(F_TARGET, 32'h90, "collision_old_target");
    fetch_only(32'h40);
    expect_f(F_HIT, 0, "alias_old_miss");
    fetch_only(32'h80);
    expect_f(F_HIT, 1, "alias_new_hit");
    expect_f(F_TARGET, 32'h100, "alias_new_target");
    expect_f(F_SB, 8, "alias_stat_br");
    expect_f(F_SM, 3, "alias_stat_mp");

    // Miss, not taken: no allocation, no mispredict.
    step(1'b1, 32'h0, 1'b1, 32'h44, 32'h300, 1'b0, 1'b0, 1'b0);
    expect_f(F_FLUSH, 0, "nalloc_flush");
    fetch_only(32'h44);
    expect_f(F_HIT, 0, "nalloc_hit");
    expect_f(F_SM, 3, "nalloc_stat_mp");

    // Reset overrides a concurrent allocating resolve.
    step(1'b0, 32'h80, 1'b1, 32'h48, 32'h200, 1'b1, 1'b0, 1'b0);
    expect_f(F_FLUSH, 0, "rst_mid_flush");
    expect_f(F_PCSEL, 0, "rst_mid_pc_sel");
    fetch_only(32'h80);
    expect_f(F_HIT, 0, "rst_cleared_hit");
    expect_f(F_SB, 0, "rst_stat_br");
    expect_f(F_SM, 0, "rst_stat_mp");
    fetch_only(32'h48);
    expect_f(F_HIT, 0, "rst_no_write_hit");

    // PC+4 wraps modulo 2^32 on fall-through recovery.
    step(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1, 1'b1);
    expect_f(F_PCSEL, 2, "wrap_pc_sel");
    expect_f(F_REDIR, 32'h0, "wrap_redirect");
    fetch_only(32'h0);
    expect_f(F_SB, 1, "wrap_stat_br");
    expect_f(F_SM, 1, "wrap_stat_mp");

    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
